// File: rtl/bus_guard_pkg.sv
// bus_guard_pkg: shared constants and types for the bus timeout guard.
//   Register offsets are byte offsets inside the 0FFFF00H IO block.
//   The register select (bus_addr[2]) is derived from those offsets so the
//   decode follows the memory map if it ever moves.
package bus_guard_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 1000;

  localparam int REG_DATA_OFS = -240;  // fault address / status
  localparam int REG_CTRL_OFS = -236;  // timeout / error count / clear

  localparam int CLR_BIT = 31;

  // Word-offset bit 0 selects between the two consecutive registers.
  localparam logic REG_SEL_DATA = 1'((REG_DATA_OFS >>> 2) & 1);
  localparam logic REG_SEL_CTRL = 1'((REG_CTRL_OFS >>> 2) & 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bus_guard.sv
// bus_guard: watches the CPU bus for cycles nobody acknowledges. When a
// strobe stays unanswered for `timeout` clocks it issues a one-cycle
// substitute ack (tout_ack) plus an error pulse (trig), and logs the
// faulting address in a small two-register block.
//
// state | meaning
// IDLE  | no bus strobe, counter at 0
// WAIT  | strobe pending, counter running
// FIRE  | tout_ack/trig high for one cycle, fault captured
//
// Ports
//   clk, rst_n          system clock, async active-low reset
//   bus_stb/we/addr     monitored CPU bus (word address [23:2])
//   dev_ack             ack from all other responders
//   stb/we/addr         register access (addr = bus_addr[2])
//   data_in/data_out    register write / read data
//   ack                 register ack (zero wait state)
//   tout_ack            substitute ack, ORed into bus_ack at top level
//   trig                error pulse to system control
module bus_guard
  import bus_guard_pkg::*;
#(
  parameter int unsigned timeout_default = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_stb,
  input  logic        bus_we,
  input  logic [21:0] bus_addr,
  input  logic        dev_ack,
  input  logic        stb,
  input  logic        we,
  input  logic        addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        tout_ack,
  output logic        trig
);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tout_ack_q, tout_ack_d;
  logic        trig_q, trig_d;
  logic [15:0] timeout_q, timeout_d;
  logic        valid_q, valid_d;
  logic        fault_we_q, fault_we_d;
  logic [23:0] fault_addr_q, fault_addr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic pending, tmo_on, hit, fire, wr_ctrl, clr;
  logic unused_data;

  assign unused_data = ^data_in[30:16];

  always_comb begin
    pending = bus_stb & ~dev_ack & ~tout_ack_q;
    tmo_on  = (timeout_q != 16'd0);
    // >= rather than == so a timeout lowered below the running count
    // still fires on the next pending cycle.
    hit     = tmo_on && (({1'b0, cnt_q} + 17'd1) >= {1'b0, timeout_q});
    fire    = (state_q == ST_FIRE);
    wr_ctrl = stb & we & (addr == REG_SEL_CTRL);
    clr     = wr_ctrl & data_in[CLR_BIT];

    state_d = state_q;
    cnt_d   = 16'd0;
    if (fire) begin
      state_d = bus_stb ? ST_WAIT : ST_IDLE;
    end else if (pending) begin
      state_d = hit ? ST_FIRE : ST_WAIT;
      if (tmo_on) cnt_d = cnt_q + 16'd1;
    end else begin
      state_d = ST_IDLE;
    end
    tout_ack_d = (state_d == ST_FIRE);
    trig_d     = (state_d == ST_FIRE);

    timeout_d    = wr_ctrl ? data_in[15:0] : timeout_q;
    valid_d      = clr ? 1'b0  : valid_q;
    fault_we_d   = clr ? 1'b0  : fault_we_q;
    fault_addr_d = clr ? 24'd0 : fault_addr_q;
    err_cnt_d    = clr ? 8'd0  : err_cnt_q;
    // Capture overrides a coincident clear.
    if (fire) begin
      valid_d      = 1'b1;
      fault_we_d   = bus_we;
      fault_addr_d = {bus_addr, 2'b00};
      err_cnt_d    = sat_inc8(clr ? 8'd0 : err_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      tout_ack_q   <= 1'b0;
      trig_q       <= 1'b0;
      timeout_q    <= 16'(timeout_default);
      valid_q      <= 1'b0;
      fault_we_q   <= 1'b0;
      fault_addr_q <= 24'd0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tout_ack_q   <= tout_ack_d;
      trig_q       <= trig_d;
      timeout_q    <= timeout_d;
      valid_q      <= valid_d;
      fault_we_q   <= fault_we_d;
      fault_addr_q <= fault_addr_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    data_out = 32'd0;
    if (stb) begin
      if (addr == REG_SEL_CTRL) data_out = {err_cnt_q, 8'd0, timeout_q};
      else if (addr == REG_SEL_DATA) data_out = {valid_q, fault_we_q, 6'd0, fault_addr_q};
    end
  end

  assign ack      = stb;
  assign tout_ack = tout_ack_q;
  assign trig     = trig_q;

endmodule

// File: tb/tb_bus_guard.sv
module tb_bus_guard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_stb, bus_we, dev_ack;
  logic [21:0] bus_addr;
  logic        stb, we, addr;
  logic [31:0] data_in, data_out;
  logic        ack, tout_ack, trig;

  bus_guard dut (
    .clk(clk), .rst_n(rst_n),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .dev_ack(dev_ack),
    .stb(stb), .we(we), .addr(addr), .data_in(data_in), .data_out(data_out),
    .ack(ack), .tout_ack(tout_ack), .trig(trig)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] val;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      tout_q[$];
  int      tests = 0;
  int      fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pops expectations whenever the DUT presents a read or a substitute ack.
  task automatic monitor();
    rd_exp_t e;
    int      ec;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stb && !we) begin
          if (rd_q.size() == 0) begin
            check("unexpected_read", 32'd1, 32'd0);
          end else begin
            e = rd_q.pop_front();
            check(e.name, data_out, e.val);
            check({e.name, "_ack"}, {31'd0, ack}, 32'd1);
          end
        end
        if (tout_ack || trig) begin
          if (tout_q.size() == 0) begin
            check("unexpected_tout", {30'd0, tout_ack, trig}, 32'd0);
          end else begin
            ec = tout_q.pop_front();
            check("tout_cycle", 32'(cyc), 32'(ec));
            check("tout_trig_pair", {30'd0, tout_ack, trig}, 32'd3);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_read(input logic a, input logic [31:0] exp, input string name);
    rd_exp_t e;
    e.name = name;
    e.val  = exp;
    rd_q.push_back(e);
    stb = 1'b1; we = 1'b0; addr = a;
    tick();
    stb = 1'b0;
  endtask

  task automatic reg_write(input logic a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    tick();
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_run(input logic [21:0] a, input logic w, input int len,
                         input int ack_at, input int wr_at, input logic [31:0] wd);
    for (int i = 1; i <= len; i++) begin
      bus_stb  = 1'b1;
      bus_addr = a;
      bus_we   = w;
      dev_ack  = (i == ack_at);
      if (i == wr_at) begin
        stb = 1'b1; we = 1'b1; addr = 1'b1; data_in = wd;
      end else begin
        stb = 1'b0; we = 1'b0;
      end
      tick();
    end
    bus_stb = 1'b0; dev_ack = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bus_stb = 1'b0; bus_we = 1'b0; bus_addr = '0; dev_ack = 1'b0;
    stb = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
    fork
      monitor();
    join_none
    #22;
    check("rst_tout_ack", {31'd0, tout_ack}, 32'd0);
    check("rst_trig", {31'd0, trig}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    reg_read(1'b1, 32'h0000_03E8, "rst_ctrl");
    reg_read(1'b0, 32'h0000_0000, "rst_fault");

    // Timeout 8, unmapped 0FFFD00H: substitute ack in cycle 9.
    reg_write(1'b1, 32'd8);
    reg_read(1'b1, 32'h0000_0008, "tmo8_ctrl");
    tout_q.push_back(cyc + 8);
    bus_run(22'h3FFF40, 1'b0, 9, 0, 0, 32'd0);
    repeat (3) tick();
    reg_read(1'b0, 32'h80FF_FD00, "fire_fault");
    reg_read(1'b1, 32'h0100_0008, "fire_ctrl");

    // dev_ack arrives in the cycle the count would hit the timeout.
    reg_write(1'b1, 32'h8000_0008);
    reg_read(1'b0, 32'h0000_0000, "clr_fault");
    reg_read(1'b1, 32'h0000_0008, "clr_ctrl");
    bus_run(22'h3FFF40, 1'b0, 8, 8, 0, 32'd0);
    repeat (3) tick();
    reg_read(1'b0, 32'h0000_0000, "late_ack_fault");
    reg_read(1'b1, 32'h0000_0008, "late_ack_ctrl");

    // Strobe held through the substitute ack: counting restarts.
    tout_q.push_back(cyc + 8);
    tout_q.push_back(cyc + 17);
    bus_run(22'h000123, 1'b1, 18, 0, 0, 32'd0);
    reg_read(1'b0, 32'hC000_048C, "restrobe_fault");
    reg_read(1'b1, 32'h0200_0008, "restrobe_ctrl");

    // Timeout lowered below the running count while waiting.
    tout_q.push_back(cyc + 6);
    bus_run(22'h2AAAAA, 1'b0, 7, 0, 5, 32'd3);
    reg_read(1'b0, 32'h80AA_AAA8, "lower_fault");
    reg_read(1'b1, 32'h0300_0003, "lower_ctrl");

    // Clear written in the FIRE cycle: capture wins.
    tout_q.push_back(cyc + 3);
    bus_run(22'h155555, 1'b1, 4, 0, 4, 32'h8000_0003);
    reg_read(1'b0, 32'hC055_5554, "clr_fire_fault");
    reg_read(1'b1, 32'h0100_0003, "clr_fire_ctrl");

    // 260 back-to-back timeouts saturate the error counter.
    for (int k = 0; k < 260; k++) tout_q.push_back(cyc + 3 + 4 * k);
    bus_run(22'h001000, 1'b0, 1040, 0, 0, 32'd0);
    reg_read(1'b1, 32'hFF00_0003, "sat_ctrl");
    reg_read(1'b0, 32'h8000_4000, "sat_fault");
    reg_write(1'b1, 32'h8000_0010);
    reg_read(1'b1, 32'h0000_0010, "sat_clr_ctrl");
    reg_read(1'b0, 32'h0000_0000, "sat_clr_fault");

    // Timeout 0 disables the guard.
    reg_write(1'b1, 32'd0);
    bus_run(22'h3FFF40, 1'b0, 1000, 0, 0, 32'd0);
    reg_read(1'b1, 32'h0000_0000, "disabled_ctrl");
    reg_read(1'b0, 32'h0000_0000, "disabled_fault");

    // Reset pulsed during FIRE while strobe is held.
    reg_write(1'b1, 32'd4);
    tout_q.push_back(cyc + 4);
    bus_stb = 1'b1; bus_addr = 22'h0ABCDE; bus_we = 1'b0;
    repeat (4) tick();
    #5;
    rst_n = 1'b0;
    #1;
    check("midrst_tout_ack", {31'd0, tout_ack}, 32'd0);
    check("midrst_trig", {31'd0, trig}, 32'd0);
    check("midrst_data_out", data_out, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    repeat (30) tick();
    bus_stb = 1'b0;
    tick();
    reg_read(1'b1, 32'h0000_03E8, "postrst_ctrl");
    reg_read(1'b0, 32'h0000_0000, "postrst_fault");

    repeat (3) tick();
    check("pending_reads", 32'(rd_q.size()), 32'd0);
    check("missed_touts", 32'(tout_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
